// File: rtl/sram_1r1w_mask_clear.sv
`default_nettype none
// sram_1r1w_mask_clear: 1R1W SRAM with lane write mask, write bypass and zero-fill sweep. Rev 1.0
// Optional macro SRAM_OUTPUT_REG_EN adds an output register stage (read latency 2).
module sram_1r1w_mask_clear #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_UNIT  = 8,
  parameter int BYPASS     = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int MASK_WIDTH = DATA_WIDTH / MASK_UNIT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  output logic                  busy,
  output logic                  wr_ready,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_dataIn,
  output logic                  rd_ready,
  input  logic                  rd_enable,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_dataOut
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   sweep_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    idle;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   rd_row;
  logic [DATA_WIDTH-1:0]   rd_merged;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  assign idle        = (state == IDLE);
  assign busy        = ~idle;
  assign wr_ready    = idle;
  assign rd_ready    = idle;
  assign wr_acc      = wr_enable & idle;
  assign rd_acc      = rd_enable & idle;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign hit         = (BYPASS != 0) && wr_acc && rd_acc && rd_in_range && (wr_addr == rd_addr);

  always_comb begin
    state_nx = state;
    case (state)
      INIT, CLEAR: if (sweep_cnt == LAST_ROW) state_nx = IDLE;
      IDLE:        if (clear) state_nx = CLEAR;
      default:     state_nx = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!idle && sweep_cnt != LAST_ROW) sweep_cnt <= sweep_cnt + 1'b1;
      else                                 sweep_cnt <= '0;
    end
  end

  // Storage has no reset; the sweep provides deterministic contents instead.
  always_ff @(posedge clock) begin
    if (!idle) begin
      mem[sweep_cnt] <= '0;
    end else if (wr_acc && wr_in_range) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wr_mask[i]) mem[wr_addr][i*MASK_UNIT +: MASK_UNIT] <= wr_dataIn[i*MASK_UNIT +: MASK_UNIT];
      end
    end
  end

  assign rd_row = rd_in_range ? mem[rd_addr] : '0;

  for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_lane
    assign rd_merged[i*MASK_UNIT +: MASK_UNIT] = (hit && wr_mask[i]) ?
        wr_dataIn[i*MASK_UNIT +: MASK_UNIT] : rd_row[i*MASK_UNIT +: MASK_UNIT];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= rd_merged;
    end
  end

`ifdef SRAM_OUTPUT_REG_EN
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) out_data_q <= rd_data_q;
    end
  end

  assign rd_valid   = out_valid_q;
  assign rd_dataOut = out_data_q;
`else
  assign rd_valid   = rd_valid_q;
  assign rd_dataOut = rd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_mask_clear.sv
`default_nettype none
// tb_sram_1r1w_mask_clear: two instances (DEPTH 16 write-first, DEPTH 12 read-first)
// driven by shared directed and random stimulus, checked against a behavioural model.
module tb_sram_1r1w_mask_clear;
`ifdef SRAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        wr_enable = 1'b0;
  logic        rd_enable = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  wr_mask = '0;
  logic [63:0] wr_data = '0;

  logic [1:0]  busy, wr_ready, rd_ready, rd_valid;
  logic [63:0] rd_data [2];

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt1 = 0;

  always #5 clock = ~clock;

  sram_1r1w_mask_clear #(.DEPTH(16), .DATA_WIDTH(64), .MASK_UNIT(8), .BYPASS(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy[0]), .wr_ready(wr_ready[0]),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_dataIn(wr_data),
    .rd_ready(rd_ready[0]), .rd_enable(rd_enable), .rd_addr(rd_addr),
    .rd_valid(rd_valid[0]), .rd_dataOut(rd_data[0]));

  sram_1r1w_mask_clear #(.DEPTH(12), .DATA_WIDTH(64), .MASK_UNIT(8), .BYPASS(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy[1]), .wr_ready(wr_ready[1]),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_dataIn(wr_data),
    .rd_ready(rd_ready[1]), .rd_enable(rd_enable), .rd_addr(rd_addr),
    .rd_valid(rd_valid[1]), .rd_dataOut(rd_data[1]));

  function automatic int dep_of(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic bit byp_of(input int k);
    return (k == 0);
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[inst %0d] @%0t got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Behavioural model: rows left to sweep, memory image, and a read delay line of LAT stages.
  logic [63:0] mmem [2][16];
  int          left [2];
  bit          pv   [2][LAT];
  logic [63:0] pd   [2][LAT];
  logic [63:0] e_data [2];

  always @(posedge clock or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      int          d;
      bit          rdy;
      logic [63:0] row;
      d = dep_of(k);
      if (!reset_n) begin
        left[k] = d;
        for (int j = 0; j < LAT; j++) pv[k][j] = 0;
        e_data[k] = '0;
      end else begin
        rdy = (left[k] == 0);
        row = '0;
        if (rdy && rd_enable && int'(rd_addr) < d) begin
          row = mmem[k][rd_addr];
          if (byp_of(k) && wr_enable && wr_addr == rd_addr)
            for (int i = 0; i < 8; i++) if (wr_mask[i]) row[i*8 +: 8] = wr_data[i*8 +: 8];
        end
        for (int j = LAT - 1; j > 0; j--) begin
          pv[k][j] = pv[k][j-1];
          pd[k][j] = pd[k][j-1];
        end
        pv[k][0] = rdy && rd_enable;
        pd[k][0] = row;
        if (pv[k][LAT-1]) e_data[k] = pd[k][LAT-1];
        if (left[k] > 0) begin
          mmem[k][d - left[k]] = '0;
          left[k]--;
        end else if (wr_enable && int'(wr_addr) < d) begin
          for (int i = 0; i < 8; i++) if (wr_mask[i]) mmem[k][wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
        end
        if (rdy && clear) left[k] = d;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("busy",     k, 64'(busy[k]),     64'(left[k] != 0));
      chk("wr_ready", k, 64'(wr_ready[k]), 64'(left[k] == 0));
      chk("rd_ready", k, 64'(rd_ready[k]), 64'(left[k] == 0));
      chk("rd_valid", k, 64'(rd_valid[k]), 64'(pv[k][LAT-1]));
      chk("rd_data",  k, rd_data[k],       e_data[k]);
    end
    if (rd_valid[1]) vcnt1++;
  end

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] m, input logic [63:0] d,
                       input logic re, input logic [3:0] ra, input logic clr);
    wr_enable = we; wr_addr = wa; wr_mask = m; wr_data = d;
    rd_enable = re; rd_addr = ra; clear = clr;
    @(negedge clock);
    wr_enable = 1'b0; rd_enable = 1'b0; clear = 1'b0;
  endtask

  task automatic pin_out(input string nm, input logic [63:0] ea, input logic [63:0] eb);
    repeat (LAT - 1) @(negedge clock);
    chk({nm, "_valid"}, 0, 64'(rd_valid[0]), 64'd1);
    chk({nm, "_valid"}, 1, 64'(rd_valid[1]), 64'd1);
    chk(nm, 0, rd_data[0], ea);
    chk(nm, 1, rd_data[1], eb);
  endtask

  task automatic measure_busy(input string nm);
    int fa, fb;
    fa = 0; fb = 0;
    for (int c = 1; c <= 60 && (fa == 0 || fb == 0); c++) begin
      @(posedge clock); #1;
      if (fa == 0 && !busy[0]) fa = c;
      if (fb == 0 && !busy[1]) fb = c;
    end
    @(negedge clock);
    chk(nm, 0, 64'(fa), 64'd16);
    chk(nm, 1, 64'(fb), 64'd12);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy != 2'b00 && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("idle_timeout", 0, 64'(busy != 2'b00), 64'd0);
  endtask

  initial begin
    int v0;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy",     k, 64'(busy[k]),     64'd1);
      chk("rst_wr_ready", k, 64'(wr_ready[k]), 64'd0);
      chk("rst_rd_valid", k, 64'(rd_valid[k]), 64'd0);
      chk("rst_rd_data",  k, rd_data[k],       64'd0);
    end
    reset_n = 1'b1;
    measure_busy("init_len");

    for (int r = 0; r < 16; r++) drive(0, 0, 0, 0, 1, 4'(r), 0);
    repeat (LAT) @(negedge clock);

    drive(1, 5, 8'hFF, 64'h1122334455667788, 0, 0, 0);
    drive(1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 0);
    pin_out("mask_merge", 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);

    drive(1, 3, 8'hF0, 64'hFFFFFFFFFFFFFFFF, 1, 3, 0);
    pin_out("collide", 64'hFFFFFFFF00000000, 64'h0);

    drive(1, 13, 8'hFF, 64'h5555555555555555, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 13, 0);
    pin_out("oor_read", 64'h5555555555555555, 64'h0);

    v0 = vcnt1;
    for (int r = 0; r < 12; r++) drive(0, 0, 0, 0, 1, 4'(r), 0);
    repeat (LAT) @(negedge clock);
    chk("b2b_valid_cnt", 1, 64'(vcnt1 - v0), 64'd12);

    for (int r = 0; r < 16; r++) drive(1, 4'(r), 8'hFF, {$urandom, $urandom}, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    measure_busy("clear_len");
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 2, 8'hFF, 64'hDEAD, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 4, 8'hFF, 64'hBEEF, 0, 0, 0);
    wait_idle();
    for (int r = 0; r < 16; r++) drive(0, 0, 0, 0, 1, 4'(r), 0);
    repeat (LAT) @(negedge clock);

    drive(0, 0, 0, 0, 1, 2, 1);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_flush_valid", 0, 64'(rd_valid[0]), 64'd0);
    chk("rst_flush_valid", 1, 64'(rd_valid[1]), 64'd0);
    reset_n = 1'b1;
    measure_busy("resweep_len");

    drive(0, 0, 0, 0, 1, 2, 1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("inflight_valid", 0, 64'(rd_valid[0]), 64'd0);
    chk("inflight_valid", 1, 64'(rd_valid[1]), 64'd0);
    reset_n = 1'b1;
    wait_idle();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(399) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clock);
        reset_n = 1'b1;
      end
      drive($urandom_range(1), 4'($urandom), 8'($urandom), {$urandom, $urandom},
            $urandom_range(1), 4'($urandom), $urandom_range(149) == 0);
    end
    repeat (LAT + 1) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_1r1w_mask_clear.md
# sram_1r1w_mask_clear

Single-clock, parametrised 1-read/1-write SRAM with per-unit write mask, same-cycle write-to-read bypass, and a hardware zero-fill sequencer run after reset and on demand. Successor to the per-macro 1R1W masked wrappers. Used as the scratchpad/buffer primitive wherever memory contents must be deterministic without a software clear loop. Storage is a behavioural array, so the block maps to FPGA BRAM or an ASIC macro.

## Interface

- DEPTH, 1024: number of rows; any value ≥ 2, power of two not required.
- DATA_WIDTH, 64: row width in bits.
- MASK_UNIT, 8: bits per mask lane; DATA_WIDTH must be a multiple.
- BYPASS, 1: 1 = write-first on same-cycle address collision; 0 = read-before-write.
- ADDR_WIDTH, $clog2(DEPTH): derived, not overridden.
- MASK_WIDTH, DATA_WIDTH/MASK_UNIT: derived, not overridden.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  single-cycle request to zero-fill the whole array.
- busy  out  1  high while a zero-fill sweep runs.
- wr_ready  out  1  write port can accept.
- wr_enable  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write row.
- wr_mask  in  MASK_WIDTH  bit i enables data bits [i*MASK_UNIT +: MASK_UNIT].
- wr_dataIn  in  DATA_WIDTH  write data.
- rd_ready  out  1  read port can accept.
- rd_enable  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read row.
- rd_valid  out  1  rd_dataOut carries a completed read this cycle.
- rd_dataOut  out  DATA_WIDTH  read data.

## Operation

- FSM states: INIT, IDLE, CLEAR. reset_n low forces INIT, sweep counter 0.
- INIT/CLEAR: one row per cycle written with all-zero data, full mask, counter 0 → DEPTH-1; after row DEPTH-1 → IDLE. busy=1, wr_ready=0, rd_ready=0 in both.
- IDLE: busy=0, wr_ready=1, rd_ready=1. clear=1 in IDLE → CLEAR next edge; clear outside IDLE ignored (not queued).
- Write accepted on wr_enable & wr_ready: only lanes with mask bit set are updated; wr_mask=0 is a no-op.
- Read accepted on rd_enable & rd_ready; returns the row contents at the accepting edge.
- Collision (both accepted, wr_addr==rd_addr): BYPASS=1 → masked lanes return wr_dataIn, unmasked lanes return stored data; BYPASS=0 → full old row.
- Write at cycle t, read of same row at t+1: always new data regardless of BYPASS.
- Address ≥ DEPTH: write dropped; read completes with rd_valid=1 and all-zero data.
- Requests while ready=0 are dropped, no side effect.
- rd_dataOut holds its last value until the next rd_valid.

## Timing

- Reset values: busy=1, wr_ready=0, rd_ready=0, rd_valid=0, rd_dataOut=0, state INIT.
- Sweep: first edge after reset_n release writes row 0; busy falls after exactly DEPTH edges. CLEAR is identical, starting the edge after clear is sampled.
- Read latency L: accept at edge t → rd_valid=1 and data valid for the cycle after edge t+L-1. Without macro L=1, with macro L=2. Fully pipelined: one read per cycle.
- Reads accepted before a CLEAR starts still complete with pre-clear data.
- reset_n asserted mid-sweep or mid-read: pipeline flushed (rd_valid=0), sweep restarts at row 0.

## Configuration

- SRAM_OUTPUT_REG_EN defined: extra output register after the array/bypass mux; L=2; rd_valid delayed to match; reset value of the extra stage is 0.
- Not defined: L=1, data taken directly from the array read register plus the bypass merge.

## Test plan

- Reset release with DEPTH=16 → busy high 16 cycles then low; reads of rows 0..15 all return 0, rd_valid exactly L cycles after each accept.
- Write row 5 = 0x1122334455667788, mask 0xFF; then write 0xAAAA... with mask 0x0F → read returns 0x11223344AAAAAAAA.
- Same-cycle write row 3 = all-ones, mask 0xF0, read row 3 (row holds 0): BYPASS=1 → 0xFFFFFFFF00000000; BYPASS=0 → 0.
- clear pulse in IDLE after filling rows → busy high DEPTH cycles, wr_enable pulses during sweep ignored, all rows read 0 afterwards; second clear during sweep causes no extra sweep.
- reset_n pulsed low at sweep row 7 with a read in flight → rd_valid stays 0, busy stays high a full DEPTH cycles from release.
- DEPTH=12, write/read address 13 → write dropped, read returns 0 with rd_valid=1; back-to-back reads of 12 rows produce 12 consecutive rd_valid cycles.
